seven_segment_scanner: RTL

Parametrised multiplexed seven-segment display driver, the successor to the fixed 8-digit hex controller. It adds configurable digit count, per-digit decimal points and blanking, and leading-zero suppression. It also adds PWM brightness, an anti-ghosting guard interval and a tear-free double-buffered value load. It sits between the debug/status registers and the board's common-anode display pins.

---
 rtl/seven_segment_scanner.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/seven_segment_scanner.sv
// Multiplexed common-anode seven-segment driver with a double-buffered value,
// leading-zero suppression, per-digit blanking, PWM brightness and an anti-ghosting guard.
module seven_segment_scanner #(
  parameter int NUM_DIGITS   = 8,
  parameter int COUNT_TO     = 100_000,
  parameter int BLANK_CYCLES = 2,
  parameter int BRIGHT_W     = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [4*NUM_DIGITS-1:0] val_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_suppress_in,
  input  logic [BRIGHT_W-1:0]     brightness_in,
  output logic [6:0]              cat_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done_out
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (COUNT_TO > 0) ? $clog2(COUNT_TO + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] DWELL_END = CNT_W'(COUNT_TO);
  localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(BLANK_CYCLES);

  logic [IDX_W-1:0]        digit_idx;
  logic [CNT_W-1:0]        dwell;
  logic [BRIGHT_W-1:0]     pwm;
  logic [4*NUM_DIGITS-1:0] staging;
  logic [NUM_DIGITS-1:0]   staging_dp;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic                    pending;
  logic                    frame_wrapped;

  logic                    wrap;
  logic                    acc;
  logic [NUM_DIGITS-1:0]   zero_from;
  logic [3:0]              cur_nibble;
  logic                    blanked;
  logic                    suppressed;
  logic                    lit;
  logic [6:0]              seg_on;
  logic                    dp_on;
  logic [NUM_DIGITS-1:0]   an_next;

  function automatic logic [6:0] hex_font(input logic [3:0] nib);
    case (nib)
      4'h0: hex_font = 7'h3F;
      4'h1: hex_font = 7'h06;
      4'h2: hex_font = 7'h5B;
      4'h3: hex_font = 7'h4F;
      4'h4: hex_font = 7'h66;
      4'h5: hex_font = 7'h6D;
      4'h6: hex_font = 7'h7D;
      4'h7: hex_font = 7'h07;
      4'h8: hex_font = 7'h7F;
      4'h9: hex_font = 7'h6F;
      4'hA: hex_font = 7'h77;
      4'hB: hex_font = 7'h7C;
      4'hC: hex_font = 7'h39;
      4'hD: hex_font = 7'h5E;
      4'hE: hex_font = 7'h79;
      default: hex_font = 7'h71;
    endcase
  endfunction

  assign wrap = (dwell == DWELL_END) && (digit_idx == LAST_IDX);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      dwell     <= '0;
      digit_idx <= '0;
      pwm       <= '0;
    end else begin
      pwm <= pwm + 1'b1;
      if (dwell == DWELL_END) begin
        dwell     <= '0;
        digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
      end else begin
        dwell <= dwell + 1'b1;
      end
    end
  end

  // A load landing on the wrap edge goes straight to shadow so it shows in the frame starting now.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      staging    <= '0;
      staging_dp <= '0;
      shadow     <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
    end else if (wrap) begin
      if (load_in) begin
        shadow    <= val_in;
        shadow_dp <= dp_in;
        pending   <= 1'b0;
      end else if (pending) begin
        shadow    <= staging;
        shadow_dp <= staging_dp;
        pending   <= 1'b0;
      end
    end else if (load_in) begin
      staging    <= val_in;
      staging_dp <= dp_in;
      pending    <= 1'b1;
    end
  end

  // zero_from[i] is set when every shadow nibble from i up to the top digit is zero.
  always_comb begin
    acc       = 1'b1;
    zero_from = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      acc          = acc & (shadow[4*i +: 4] == 4'h0);
      zero_from[i] = acc;
    end
  end

  always_comb begin
    cur_nibble = shadow[{digit_idx, 2'b00} +: 4];
    blanked    = blank_in[digit_idx];
    suppressed = lz_suppress_in && (digit_idx != '0) && zero_from[digit_idx];
    lit        = (dwell >= GUARD_END) && ((&brightness_in) || (pwm < brightness_in)) && !blanked;
    seg_on     = (blanked || suppressed) ? 7'h00 : hex_font(cur_nibble);
    dp_on      = !blanked && shadow_dp[digit_idx];
    an_next    = '1;
    if (lit) an_next[digit_idx] = 1'b0;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cat_out        <= 7'h7F;
      dp_out         <= 1'b1;
      an_out         <= '1;
      frame_wrapped  <= 1'b0;
      frame_done_out <= 1'b0;
    end else begin
      cat_out        <= ~seg_on;
      dp_out         <= ~dp_on;
      an_out         <= an_next;
      frame_wrapped  <= wrap;
      frame_done_out <= frame_wrapped;
    end
  end

endmodule
